// File: rtl/alu_pipe_core.sv
// alu_pipe_core: two-stage pipelined ALU with a multiply-accumulate register
// and a sticky accumulator wrap flag. Stage 1 captures the operand set.
// Stage 2 computes the result and registers it together with the tag.
module alu_pipe_core #(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned RES_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [2:0]       opcode,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [OP_W-1:0]  addr_in,
  output logic             valid_out,
  output logic [RES_W-1:0] result,
  output logic [OP_W-1:0]  addr_out,
  output logic             acc_ovf
);

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_ACC = 3'd6,
    OP_CLR = 3'd7
  } op_e;

  // Stage 1 registers
  logic            s1_valid_q;
  op_e             s1_op_q;
  logic [OP_W-1:0] s1_a_q;
  logic [OP_W-1:0] s1_b_q;
  logic [OP_W-1:0] s1_addr_q;

  // Stage 2 registers and architectural state
  logic             valid_q;
  logic [RES_W-1:0] result_q, result_d;
  logic [OP_W-1:0]  addr_q;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  // Operands widened to the result width
  logic [RES_W-1:0] ext_a, ext_b, prod;
  logic [RES_W:0]   acc_sum;

  assign ext_a   = RES_W'(s1_a_q);
  assign ext_b   = RES_W'(s1_b_q);
  assign prod    = ext_a * ext_b;
  assign acc_sum = {1'b0, acc_q} + {1'b0, prod};

  // Stage 1: capture the operand set every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_NOP;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= valid_in;
      s1_op_q    <= op_e'(opcode);
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_addr_q  <= addr_in;
    end
  end

  // Stage 2 datapath: result, next accumulator and next wrap flag.
  // The accumulator is updated at the same edge the ACC result is registered.
  // So back-to-back ACCs already see every earlier update without forwarding.
  always_comb begin
    result_d = '0;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    unique case (s1_op_q)
      OP_NOP: result_d = '0;
      OP_ADD: result_d = ext_a + ext_b;
      OP_SUB: result_d = ext_a - ext_b;
      OP_AND: result_d = ext_a & ext_b;
      OP_XOR: result_d = ext_a ^ ext_b;
      OP_MUL: result_d = prod;
      OP_ACC: begin
        acc_d    = acc_sum[RES_W-1:0];
        ovf_d    = ovf_q | acc_sum[RES_W];
        result_d = acc_sum[RES_W-1:0];
      end
      OP_CLR: begin
        acc_d    = '0;
        ovf_d    = 1'b0;
        result_d = '0;
      end
      default: result_d = '0;
    endcase
  end

  // Stage 2: only valid transactions update the result, tag, accumulator and flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        addr_q   <= s1_addr_q;
        acc_q    <= acc_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign valid_out = valid_q;
  assign result    = result_q;
  assign addr_out  = addr_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_pipe_core.sv
// tb_alu_pipe_core: scoreboard bench. The driver issues transactions.
// It pushes the reference-model response into a queue.
// An independent monitor pops the queue whenever valid_out is seen.
module tb_alu_pipe_core;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;
  localparam longint      MOD   = longint'(1) << RES_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [2:0]       opcode;
  logic [OP_W-1:0]  a, b, addr_in;
  logic             valid_out;
  logic [RES_W-1:0] result;
  logic [OP_W-1:0]  addr_out;
  logic             acc_ovf;

  alu_pipe_core #(.OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode),
    .a(a), .b(b), .addr_in(addr_in), .valid_out(valid_out),
    .result(result), .addr_out(addr_out), .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [RES_W-1:0] res;
    logic [OP_W-1:0]  addr;
    logic             ovf;
    int unsigned      due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: the accumulator as plain integer arithmetic
  longint acc_m = 0;
  bit     ovf_m = 1'b0;

  function automatic longint model(input int op, input longint x, input longint y);
    longint t;
    case (op)
      1: return x + y;
      2: return (x - y + MOD) % MOD;
      3: return x & y;
      4: return x ^ y;
      5: return x * y;
      6: begin
        t = acc_m + x * y;
        if (t >= MOD) ovf_m = 1'b1;
        acc_m = t % MOD;
        return acc_m;
      end
      7: begin
        acc_m = 0;
        ovf_m = 1'b0;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  // Issue one valid transaction; use_k substitutes a hand-derived expectation
  task automatic send(input int op, input int x, input int y, input int tag,
                      input bit use_k = 1'b0, input int k_res = 0, input bit k_ovf = 1'b0);
    exp_t   e;
    longint r;
    @(posedge clk); #1;
    valid_in = 1'b1;
    opcode   = 3'(op);
    a        = OP_W'(x);
    b        = OP_W'(y);
    addr_in  = OP_W'(tag);
    r        = model(op, x, y);
    e.res    = use_k ? RES_W'(k_res) : RES_W'(r);
    e.ovf    = use_k ? k_ovf : ovf_m;
    e.addr   = OP_W'(tag);
    e.due    = cyc + 2;
    sb.push_back(e);
  endtask

  // Bubble cycle with random, ignored operands (including ACC/CLR opcodes)
  task automatic idle();
    @(posedge clk); #1;
    valid_in = 1'b0;
    opcode   = 3'($urandom_range(7));
    a        = OP_W'($urandom);
    b        = OP_W'($urandom);
    addr_in  = OP_W'($urandom);
  endtask

  // Monitor: compare every output cycle against the scoreboard
  logic [RES_W-1:0] last_res  = '0;
  logic [OP_W-1:0]  last_addr = '0;
  logic             ovf_cur   = 1'b0;
  exp_t             got_e;

  always @(negedge clk) begin
    if (reset) begin
      chk("valid_out_in_reset", valid_out, 0);
      last_res  = '0;
      last_addr = '0;
      ovf_cur   = 1'b0;
    end else if (valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        got_e = sb.pop_front();
        chk("result", result, got_e.res);
        chk("addr_out", addr_out, got_e.addr);
        chk("latency_cycle", cyc, got_e.due);
        ovf_cur   = got_e.ovf;
        last_res  = got_e.res;
        last_addr = got_e.addr;
      end
    end else begin
      chk("result_hold", result, last_res);
      chk("addr_hold", addr_out, last_addr);
    end
    chk("acc_ovf", acc_ovf, ovf_cur);
  end

  initial begin
    valid_in = 1'b0; opcode = '0; a = '0; b = '0; addr_in = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_result", result, 0);
    chk("rst_addr_out", addr_out, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed vectors with hand-derived results
    send(1, 8'hFF, 8'h01, 8'h12, 1'b1, 16'h0100, 1'b0);
    send(2, 8'h03, 8'h05, 8'h20, 1'b1, 16'hFFFE, 1'b0);
    send(5, 8'hFF, 8'hFF, 8'h21, 1'b1, 16'hFE01, 1'b0);
    send(0, 8'h12, 8'h34, 8'h22, 1'b1, 16'h0000, 1'b0);
    send(3, 8'hF0, 8'h3C, 8'h23, 1'b1, 16'h0030, 1'b0);
    send(4, 8'hF0, 8'h3C, 8'h24, 1'b1, 16'h00CC, 1'b0);
    send(7, 0, 0, 8'h30, 1'b1, 16'h0000, 1'b0);
    send(6, 3, 4, 8'h31, 1'b1, 16'h000C, 1'b0);
    send(6, 2, 5, 8'h32, 1'b1, 16'h0016, 1'b0);
    send(6, 1, 1, 8'h33, 1'b1, 16'h0017, 1'b0);
    send(7, 0, 0, 8'h40, 1'b1, 16'h0000, 1'b0);
    send(6, 8'hFF, 8'hFF, 8'h41, 1'b1, 16'hFE01, 1'b0);
    send(6, 8'hFF, 8'hFF, 8'h42, 1'b1, 16'hFC02, 1'b1);
    idle();
    send(6, 1, 1, 8'h43, 1'b1, 16'hFC03, 1'b1);  // flag stays sticky
    send(7, 0, 0, 8'h44, 1'b1, 16'h0000, 1'b0);
    send(1, 1, 1, 8'h01, 1'b1, 16'h0002, 1'b0);
    idle();
    send(1, 2, 2, 8'h02, 1'b1, 16'h0004, 1'b0);
    idle();
    send(1, 3, 3, 8'h03, 1'b1, 16'h0006, 1'b0);
    repeat (3) idle();

    // Reset one cycle after an ADD: the in-flight tag 0x55 is discarded
    send(1, 8'h10, 8'h20, 8'h55);
    @(posedge clk); #1;
    valid_in = 1'b0;
    reset    = 1'b1;
    sb.delete();
    acc_m = 0;
    ovf_m = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_result", result, 0);
    chk("midrst_addr_out", addr_out, 0);
    chk("midrst_acc_ovf", acc_ovf, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send(1, 8'h11, 8'h22, 8'h66, 1'b1, 16'h0033, 1'b0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) idle();
      else send(int'($urandom_range(7)), int'($urandom_range(255)),
                int'($urandom_range(255)), int'($urandom_range(255)));
    end
    idle();

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_pipe_core.md
ALU_PIPE_CORE -- requirements
Module: alu_pipe_core

Interface
REQ-001 Parameter OP_W, default 8, width of operands a, b and of addr_in/addr_out.
REQ-002 Parameter RES_W, default 16, width of result and of the internal accumulator; must be >= 2*OP_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valid_in  input  1  operand set on a/b/opcode/addr_in is valid this cycle.
REQ-006 opcode  input  3  operation: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 XOR, 5 MUL, 6 ACC, 7 CLR.
REQ-007 a, b  input  OP_W each  unsigned operands.
REQ-008 addr_in  input  OP_W  transaction tag, carried through unchanged.
REQ-009 valid_out  output  1  result/addr_out hold a new completed transaction this cycle.
REQ-010 result  output  RES_W  operation result.
REQ-011 addr_out  output  OP_W  tag of the transaction in result.
REQ-012 acc_ovf  output  1  sticky accumulator wrap flag.

Function
REQ-013 Two-stage pipeline: stage 1 registers valid_in/opcode/a/b/addr_in on the rising edge; stage 2 registers result/addr_out/valid_out on the next rising edge.
REQ-014 Latency is exactly 2 clocks: inputs sampled at edge N appear on outputs just after edge N+2; throughput one transaction per clock, no stalls, no backpressure.
REQ-015 valid_in low at edge N creates a bubble: valid_out low after edge N+2; result and addr_out hold their previous values.
REQ-016 NOP with valid_in high: valid_out high, addr_out updated, result 0.
REQ-017 ADD: result = zero-extended a + b (carry in bit OP_W).
REQ-018 SUB: result = (a - b) modulo 2^RES_W, i.e. two's-complement sign-extended difference.
REQ-019 AND, XOR: bitwise on OP_W bits, zero-extended to RES_W.
REQ-020 MUL: result = full unsigned a * b, 2*OP_W bits, zero-extended.
REQ-021 ACC: accumulator = (accumulator + a*b) modulo 2^RES_W; result = updated accumulator value.
REQ-022 ACC on consecutive valid cycles: each ACC uses the accumulator value including all earlier ACC/CLR transactions (internal forwarding; no hazard visible to the user).
REQ-023 ACC whose true sum >= 2^RES_W sets acc_ovf at the same edge its result appears; acc_ovf stays set until CLR or reset.
REQ-024 CLR: accumulator = 0, acc_ovf cleared at the edge its result appears, result 0.
REQ-025 ACC/CLR with valid_in low: no effect on accumulator or acc_ovf.
REQ-026 Only valid transactions change accumulator, acc_ovf, result or addr_out.

Reset
REQ-027 While reset high: valid_out 0, result 0, addr_out 0, acc_ovf 0, accumulator 0, both stage valids 0, independent of clk.
REQ-028 Reset asserted mid-operation discards all in-flight transactions; none appear on valid_out after reset release.
REQ-029 First valid_in sampled on the first rising edge after reset deasserts is processed normally with 2-clock latency.

Verification
REQ-030 ADD a=0xFF b=0x01 addr_in=0x12 at edge N -> edge N+2: valid_out=1, result=0x0100, addr_out=0x12.
REQ-031 SUB a=0x03 b=0x05 -> result=0xFFFE; MUL a=0xFF b=0xFF -> result=0xFE01.
REQ-032 Back-to-back CLR, ACC(3,4), ACC(2,5), ACC(1,1) on 4 consecutive edges -> results 0x0000, 0x000C, 0x0016, 0x0017 on 4 consecutive edges, acc_ovf=0.
REQ-033 CLR then ACC(0xFF,0xFF) x2 -> results 0xFE01, 0xFC02 with acc_ovf=1 from the second; subsequent CLR -> result 0, acc_ovf=0.
REQ-034 Alternating valid_in 1/0 with ADD tags 0x01,0x02,0x03 -> valid_out pattern 1/0/1/0/1, addr_out 0x01,0x02,0x03, result held during bubbles.
REQ-035 Assert reset one cycle after issuing ADD tag 0x55 -> no valid_out for 0x55; all outputs 0 immediately; post-release ADD processed with 2-clock latency.
